// File: rtl/decoder5to32_seq_pkg.sv
// decoder5to32_seq shared types.
// Window FSM state encoding.
package decoder5to32_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/decoder5to32_seq_if.sv
// Code-in / one-hot-out bus for decoder5to32_seq.
// master drives codes, slave is the decoder.
interface decoder5to32_seq_if;

   logic        in_valid;
   logic        in_ready;
   logic [4:0]  A;
   logic        E;
   logic [31:0] Y;
   logic        V;
   logic        busy;
   logic        done;

   modport master (
      output in_valid, A, E,
      input  in_ready, Y, V, busy, done
   );

   modport slave (
      input  in_valid, A, E,
      output in_ready, Y, V, busy, done
   );

endinterface

// File: rtl/decoder5to32_seq_dec.sv
// Combinational 5-to-32 one-hot decoder with enable.
// en=0 forces an all-zero output.
module decoder5to32 (
   input  logic [4:0]  a,
   input  logic        en,
   output logic [31:0] y
);

   always_comb begin
      y = '0;
      if (en) y[a] = 1'b1;
   end

endmodule

// File: rtl/decoder5to32_seq.sv
// Registered 5-to-32 decoder with valid/ready input
// and a timed HOLD/GAP output window per accepted code.
module decoder5to32_seq
   import decoder5to32_seq_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 1,
   parameter int CNT_W       = 16
) (
   input logic             clk,
   input logic             rst,
   decoder5to32_seq_if.slave bus
);

   localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > CNT_MAX ||
       GAP_CYCLES < 0 || GAP_CYCLES > CNT_MAX)
   begin : g_bad_cfg
      $error("decoder5to32_seq: HOLD/GAP out of range");
   end

   localparam logic [CNT_W-1:0] HOLD_LD =
      CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LD =
      CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam bit NO_GAP = (GAP_CYCLES == 0);

   state_t           state;
   state_t           nstate;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] ncnt;
   logic [4:0]       a_q;
   logic             e_q;
   logic [31:0]      y_q;
   logic [31:0]      y_next;
   logic [31:0]      dec_y;
   logic [4:0]       dec_a;
   logic             dec_e;
   logic             xfer;
   logic             cnt_zero;

   assign xfer     = bus.in_valid && (state == IDLE);
   assign cnt_zero = (cnt == '0);

   // Decode the live code on the accepting edge so Y is
   // one-hot in the very first HOLD cycle.
   assign dec_a = xfer ? bus.A : a_q;
   assign dec_e = xfer ? bus.E : e_q;

   decoder5to32 u_dec (
      .a  (dec_a),
      .en (dec_e),
      .y  (dec_y)
   );

   always_comb begin
      nstate = state;
      ncnt   = cnt;
      unique case (state)
         IDLE: begin
            if (xfer) begin
               nstate = HOLD;
               ncnt   = HOLD_LD;
            end
         end
         HOLD: begin
            if (!cnt_zero) begin
               ncnt = cnt - 1'b1;
            end else if (NO_GAP) begin
               nstate = IDLE;
               ncnt   = '0;
            end else begin
               nstate = GAP;
               ncnt   = GAP_LD;
            end
         end
         GAP: begin
            if (!cnt_zero) begin
               ncnt = cnt - 1'b1;
            end else begin
               nstate = IDLE;
            end
         end
         default: begin
            nstate = IDLE;
            ncnt   = '0;
         end
      endcase
   end

   assign y_next = (nstate == HOLD) ? dec_y : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         a_q   <= '0;
         e_q   <= 1'b0;
         y_q   <= '0;
      end else begin
         state <= nstate;
         cnt   <= ncnt;
         y_q   <= y_next;
         if (xfer) begin
            a_q <= bus.A;
            e_q <= bus.E;
         end
      end
   end

   assign bus.Y        = y_q;
   assign bus.V        = |y_q;
   assign bus.busy     = (state != IDLE);
   assign bus.in_ready = (state == IDLE);
   assign bus.done     = cnt_zero &&
      ((state == GAP) || (state == HOLD && NO_GAP));

endmodule

// File: tb/tb_decoder5to32_seq.sv
// Scoreboard bench for decoder5to32_seq: two instances
// (HOLD=4/GAP=1 and HOLD=1/GAP=0) driven by directed codes.
module tb_decoder5to32_seq;

   typedef struct packed {
      logic [31:0] y;
      logic        done;
   } exp_t;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   last_hs;

   exp_t q0[$];
   exp_t q1[$];

   decoder5to32_seq_if ifc0 ();
   decoder5to32_seq_if ifc1 ();

   decoder5to32_seq #(
      .HOLD_CYCLES (4),
      .GAP_CYCLES  (1),
      .CNT_W       (16)
   ) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (ifc0)
   );

   decoder5to32_seq #(
      .HOLD_CYCLES (1),
      .GAP_CYCLES  (0),
      .CNT_W       (16)
   ) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (ifc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [31:0] act,
                      logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t",
                  nm, act, exp, $time);
      end
   endtask

   // Monitors: every busy cycle must match the next
   // expected window entry.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && ifc0.busy) begin
         if (q0.size() == 0) begin
            chk("mon0 underflow", 32'(q0.size()), 1);
         end else begin
            e = q0.pop_front();
            chk("mon0 Y", ifc0.Y, e.y);
            chk("mon0 V", 32'(ifc0.V), 32'(e.y != 0));
            chk("mon0 done", 32'(ifc0.done), 32'(e.done));
         end
      end else if (!rst) begin
         chk("mon0 idle Y", ifc0.Y, 0);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst && ifc1.busy) begin
         if (q1.size() == 0) begin
            chk("mon1 underflow", 32'(q1.size()), 1);
         end else begin
            e = q1.pop_front();
            chk("mon1 Y", ifc1.Y, e.y);
            chk("mon1 V", 32'(ifc1.V), 32'(e.y != 0));
            chk("mon1 done", 32'(ifc1.done), 32'(e.done));
         end
      end else if (!rst) begin
         chk("mon1 idle Y", ifc1.Y, 0);
      end
   end

   task automatic drive(int d, logic v, logic [4:0] a,
                        logic e);
      if (d == 0) begin
         ifc0.in_valid = v; ifc0.A = a; ifc0.E = e;
      end else begin
         ifc1.in_valid = v; ifc1.A = a; ifc1.E = e;
      end
   endtask

   function automatic logic rdy(int d);
      return (d == 0) ? ifc0.in_ready : ifc1.in_ready;
   endfunction

   function automatic logic bsy(int d);
      return (d == 0) ? ifc0.busy : ifc1.busy;
   endfunction

   task automatic push(int d, exp_t x);
      if (d == 0) q0.push_back(x);
      else q1.push_back(x);
   endtask

   // Called at a negedge; returns at the negedge of the
   // first HOLD cycle.
   task automatic xfer(int d, logic [4:0] a, logic e,
                       logic [31:0] ey, int h, int g,
                       bit keep);
      int n;
      drive(d, 1'b1, a, e);
      n = 0;
      while (!rdy(d) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("handshake ready", 32'(rdy(d)), 1);
      last_hs = cyc;
      for (int i = 0; i < h; i++)
         push(d, '{y: ey, done: (g == 0 && i == h - 1)});
      for (int i = 0; i < g; i++)
         push(d, '{y: 32'h0, done: (i == g - 1)});
      @(negedge clk);
      if (!keep) drive(d, 1'b0, a, e);
   endtask

   task automatic ready_gap(int d, int want);
      int n;
      n = 0;
      while (!rdy(d) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("busy cycles before ready", n, want);
   endtask

   task automatic settle(int d);
      int n;
      n = 0;
      while (bsy(d) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("settle busy", 32'(bsy(d)), 0);
      chk("drain queue",
          (d == 0) ? q0.size() : q1.size(), 0);
   endtask

   task automatic chk_reset(int d, string nm);
      if (d == 0) begin
         chk({nm, " Y"}, ifc0.Y, 0);
         chk({nm, " V"}, 32'(ifc0.V), 0);
         chk({nm, " ready"}, 32'(ifc0.in_ready), 1);
         chk({nm, " busy"}, 32'(ifc0.busy), 0);
         chk({nm, " done"}, 32'(ifc0.done), 0);
      end else begin
         chk({nm, " Y"}, ifc1.Y, 0);
         chk({nm, " V"}, 32'(ifc1.V), 0);
         chk({nm, " ready"}, 32'(ifc1.in_ready), 1);
         chk({nm, " busy"}, 32'(ifc1.busy), 0);
         chk({nm, " done"}, 32'(ifc1.done), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0]  codes [3];
      logic [31:0] ys    [3];
      int          prev;

      codes = '{5'd0, 5'd1, 5'd31};
      ys    = '{32'h0000_0001, 32'h0000_0002,
                32'h8000_0000};

      rst = 1'b1;
      drive(0, 1'b0, 5'd0, 1'b0);
      drive(1, 1'b0, 5'd0, 1'b0);
      repeat (2) @(negedge clk);
      chk_reset(0, "rst0");
      chk_reset(1, "rst1");
      rst = 1'b0;
      @(negedge clk);

      // single enabled code
      xfer(0, 5'd27, 1'b1, 32'h0800_0000, 4, 1, 1'b0);
      ready_gap(0, 5);
      settle(0);

      // disabled code: same timing, Y stays zero
      xfer(0, 5'd3, 1'b0, 32'h0, 4, 1, 1'b0);
      ready_gap(0, 5);
      settle(0);

      // back-to-back with in_valid held high
      prev = 0;
      for (int i = 0; i < 3; i++) begin
         xfer(0, codes[i], 1'b1, ys[i], 4, 1, i < 2);
         if (i > 0) chk("b2b spacing", last_hs - prev, 6);
         prev = last_hs;
      end
      settle(0);

      // no-gap instance, one-cycle hold
      xfer(1, 5'd16, 1'b1, 32'h0001_0000, 1, 0, 1'b0);
      ready_gap(1, 1);
      settle(1);
      xfer(1, 5'd5, 1'b1, 32'h0000_0020, 1, 0, 1'b0);
      settle(1);

      // reset while idle with in_valid asserted
      drive(0, 1'b1, 5'd9, 1'b1);
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk_reset(0, "rst_iv");
      end
      drive(0, 1'b0, 5'd9, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      chk("post rst busy", 32'(ifc0.busy), 0);

      // reset during second HOLD cycle
      xfer(0, 5'd10, 1'b1, 32'h0000_0400, 4, 1, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 chk_reset(0, "rst_hold");
      q0.delete();
      repeat (2) begin
         @(negedge clk);
         chk("rst_hold no done", 32'(ifc0.done), 0);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort busy", 32'(ifc0.busy), 0);
      xfer(0, 5'd10, 1'b1, 32'h0000_0400, 4, 1, 1'b0);
      ready_gap(0, 5);
      settle(0);

      chk("final q0", q0.size(), 0);
      chk("final q1", q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
